snake_body_tracker: RTL and testbench
=====================================

SNAKE_BODY_TRACKER -- requirements
Module: snake_body_tracker

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum body segments held (power of two).
REQ-002 SHALL have parameter W, default 10, coordinate width matching the playfield position buses.
REQ-003 SHALL have port slow_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port head_valid  input  1  new head position offered.
REQ-006 SHALL have port head_x / head_y  input  W each  head top-left coordinate (0..95 / 0..63).
REQ-007 SHALL have port grow  input  1  sampled with an accepted head; body lengthens by one.
REQ-008 SHALL have port head_ready  output  1  tracker can accept a head this cycle.
REQ-009 SHALL have port push_done  output  1  one-cycle pulse when a push completes.
REQ-010 SHALL have port self_hit  output  1  sticky: an accepted head landed on a live body segment.
REQ-011 SHALL have port q_valid / q_x / q_y  input  1 / W / W  renderer pixel query.
REQ-012 SHALL have port q_ready  output  1  query can be accepted this cycle.
REQ-013 SHALL have port r_valid / r_hit  output  1 / 1  one-cycle query result; r_hit = pixel is a body segment.
REQ-014 SHALL have port length  output  $clog2(MAX_LEN)+1  live segment count.

Function
REQ-015 SHALL store segments in a circular buffer indexed by wr_ptr (next head slot); segment k (k=0 newest) sits at wr_ptr-1-k mod MAX_LEN.
REQ-016 SHALL implement FSM IDLE, PUSH_SCAN, QUERY_SCAN; head_ready = q_ready = (state==IDLE).
REQ-017 SHALL, when head_valid and q_valid are both high in IDLE, accept the head only; the query stays pending.
REQ-018 SHALL define a push's compare count C = length if growing, else max(length-1,0); growing = grow && length<MAX_LEN (saturating).
REQ-019 SHALL in PUSH_SCAN compare one segment per cycle (k=0..C-1) against the latched head; any match sets self_hit.
REQ-020 SHALL, for a head accepted in cycle N, write the head, advance wr_ptr, update length and pulse push_done in cycle N+C+1, then return to IDLE.
REQ-021 SHALL set length to min(length+1,MAX_LEN) when growing or length==0; otherwise keep length (oldest segment retired).
REQ-022 SHALL in QUERY_SCAN compare one segment per cycle over k=0..length-1 and pulse r_valid in cycle N+length+1 for a query accepted in cycle N.
REQ-023 SHALL, with length==0, complete a query with r_valid at N+1, r_hit=0, and a push with push_done at N+1.
REQ-024 SHALL keep self_hit high until reset; further pushes still execute normally.
REQ-025 SHALL hold r_hit stable from its r_valid pulse until the next r_valid.
REQ-026 SHALL ignore head_valid/q_valid while not in IDLE; there is no queuing.

Reset
REQ-027 SHALL on reset asynchronously force: state IDLE, wr_ptr 0, length 0, self_hit 0, push_done 0, r_valid 0, r_hit 0; buffer contents unreset.
REQ-028 SHALL abandon any scan in progress on reset mid-operation with no write and no result pulse.

Structure
REQ-029 SHALL place playfield constants (MAX_X=95, MAX_Y=63), W and the FSM state encoding in the shared snake package.
REQ-030 SHALL use one sub-module, snake_seg_ram (MAX_LEN x 2W, one synchronous write port, one async read port).

Verification
REQ-031 SHALL cover: reset, push (10,20) grow=0 -> push_done at N+1, length=1, self_hit=0.
REQ-032 SHALL cover: four pushes (10..13,20) grow=1, query (12,20) -> r_valid at N+5, r_hit=1; query (14,20) -> r_hit=0.
REQ-033 SHALL cover: length=4, push grow=0 -> length stays 4, oldest (10,20) no longer hits, push_done at N+4.
REQ-034 SHALL cover: push head equal to segment k=2 -> self_hit=1 and stays 1 across later pushes.
REQ-035 SHALL cover: 17 grow pushes with MAX_LEN=16 -> length saturates at 16; head_valid+q_valid same cycle -> push served, query accepted after push_done.
REQ-036 SHALL cover: reset asserted mid QUERY_SCAN -> no r_valid, length=0, head_ready=1 immediately.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake playfield constants, coordinate width and tracker FSM states.
// Imported by the body tracker; no ports.
package snake_pkg;

    localparam int MAX_X = 95;
    localparam int MAX_Y = 63;
    localparam int W     = 10;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PUSH_SCAN  = 2'd1,
        QUERY_SCAN = 2'd2
    } state_t;

endpackage

// File: rtl/snake_seg_ram.sv
// Segment store: DEPTH x DW, one synchronous write port, one async read port.
// Ports: slow_clk, we/wr_addr/wr_data (write), rd_addr/rd_data (read).
module snake_seg_ram #(
    parameter int DEPTH = 16,
    parameter int DW    = 20
) (
    input  logic                     slow_clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DW-1:0]            rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge slow_clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/snake_body_tracker.sv
// Snake body tracker: circular segment buffer with serial self-hit and pixel scans.
// Ports: slow_clk, reset, head push (valid/x/y/grow/ready/push_done/self_hit),
// pixel query (q_valid/q_x/q_y/q_ready, r_valid/r_hit), length.
module snake_body_tracker
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int W       = snake_pkg::W
) (
    input  logic                       slow_clk,
    input  logic                       reset,
    input  logic                       head_valid,
    input  logic [W-1:0]               head_x,
    input  logic [W-1:0]               head_y,
    input  logic                       grow,
    output logic                       head_ready,
    output logic                       push_done,
    output logic                       self_hit,
    input  logic                       q_valid,
    input  logic [W-1:0]               q_x,
    input  logic [W-1:0]               q_y,
    output logic                       q_ready,
    output logic                       r_valid,
    output logic                       r_hit,
    output logic [$clog2(MAX_LEN):0]   length
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = AW + 1;

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [LW-1:0]   k;
    logic [LW-1:0]   last_k;
    logic [W-1:0]    cmp_x;
    logic [W-1:0]    cmp_y;
    logic            grow_lat;
    logic            q_acc;

    logic            head_take;
    logic            query_take;
    logic            grow_now;
    logic            grow_sel;
    logic [LW-1:0]   push_cnt;
    logic [LW-1:0]   len_next;
    logic            push_last;
    logic            seg_match;
    logic            we;
    logic [2*W-1:0]  wr_data;
    logic [2*W-1:0]  rd_data;
    logic [AW-1:0]   rd_addr;

    assign head_ready = (state == IDLE);
    assign q_ready    = (state == IDLE);

    // A head wins over a simultaneous query; the query simply stays pending.
    assign head_take  = head_ready && head_valid;
    assign query_take = q_ready && q_valid && !head_valid;

    assign grow_now = grow && (length < LW'(MAX_LEN));
    assign push_cnt = grow_now ? length
                    : (length == '0) ? '0 : length - LW'(1);

    assign grow_sel = (state == IDLE) ? grow_now : grow_lat;
    assign len_next = (grow_sel || length == '0) ? length + LW'(1) : length;

    // Segment k lives just behind the write pointer.
    assign rd_addr   = wr_ptr - AW'(1) - k[AW-1:0];
    assign seg_match = (rd_data == {cmp_x, cmp_y});
    assign push_last = (state == PUSH_SCAN) && (k == last_k);

    // Zero-compare pushes commit on the accepting edge itself.
    assign we      = (head_take && push_cnt == '0) || push_last;
    assign wr_data = (state == IDLE) ? {head_x, head_y} : {cmp_x, cmp_y};

    snake_seg_ram #(
        .DEPTH (MAX_LEN),
        .DW    (2*W)
    ) u_ram (
        .slow_clk (slow_clk),
        .we       (we),
        .wr_addr  (wr_ptr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            length    <= '0;
            self_hit  <= 1'b0;
            push_done <= 1'b0;
            r_valid   <= 1'b0;
            r_hit     <= 1'b0;
            k         <= '0;
            last_k    <= '0;
            cmp_x     <= '0;
            cmp_y     <= '0;
            grow_lat  <= 1'b0;
            q_acc     <= 1'b0;
        end else begin
            push_done <= 1'b0;
            r_valid   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (head_take) begin
                        cmp_x    <= head_x;
                        cmp_y    <= head_y;
                        grow_lat <= grow_now;
                        k        <= '0;
                        last_k   <= push_cnt - LW'(1);
                        if (push_cnt == '0) begin
                            wr_ptr    <= wr_ptr + AW'(1);
                            length    <= len_next;
                            push_done <= 1'b1;
                        end else begin
                            state <= PUSH_SCAN;
                        end
                    end else if (query_take) begin
                        cmp_x  <= q_x;
                        cmp_y  <= q_y;
                        k      <= '0;
                        last_k <= length - LW'(1);
                        q_acc  <= 1'b0;
                        if (length == '0) begin
                            r_valid <= 1'b1;
                            r_hit   <= 1'b0;
                        end else begin
                            state <= QUERY_SCAN;
                        end
                    end
                end
                PUSH_SCAN: begin
                    if (seg_match) self_hit <= 1'b1;
                    k <= k + LW'(1);
                    if (push_last) begin
                        wr_ptr    <= wr_ptr + AW'(1);
                        length    <= len_next;
                        push_done <= 1'b1;
                        state     <= IDLE;
                    end
                end
                QUERY_SCAN: begin
                    q_acc <= q_acc | seg_match;
                    k     <= k + LW'(1);
                    if (k == last_k) begin
                        r_valid <= 1'b1;
                        r_hit   <= q_acc | seg_match;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_body_tracker.sv
// Self-checking bench for snake_body_tracker: directed scenarios plus
// random pushes/queries against a newest-first segment queue model.
module tb_snake_body_tracker;

    localparam int MAXL = 16;
    localparam int WW   = 10;
    localparam int LIM  = 60;

    logic          slow_clk = 1'b0;
    logic          reset = 1'b1;
    logic          head_valid = 1'b0;
    logic [WW-1:0] head_x = '0;
    logic [WW-1:0] head_y = '0;
    logic          grow = 1'b0;
    logic          head_ready;
    logic          push_done;
    logic          self_hit;
    logic          q_valid = 1'b0;
    logic [WW-1:0] q_x = '0;
    logic [WW-1:0] q_y = '0;
    logic          q_ready;
    logic          r_valid;
    logic          r_hit;
    logic [$clog2(MAXL):0] length;

    int total = 0;
    int bad   = 0;

    logic [2*WW-1:0] segs[$];
    bit              m_self;

    always #5 slow_clk = ~slow_clk;

    snake_body_tracker #(.MAX_LEN(MAXL), .W(WW)) dut (
        .slow_clk   (slow_clk),
        .reset      (reset),
        .head_valid (head_valid),
        .head_x     (head_x),
        .head_y     (head_y),
        .grow       (grow),
        .head_ready (head_ready),
        .push_done  (push_done),
        .self_hit   (self_hit),
        .q_valid    (q_valid),
        .q_x        (q_x),
        .q_y        (q_y),
        .q_ready    (q_ready),
        .r_valid    (r_valid),
        .r_hit      (r_hit),
        .length     (length)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge slow_clk);
        reset = 1'b1;
        head_valid = 1'b0;
        q_valid = 1'b0;
        @(negedge slow_clk);
        reset = 1'b0;
        segs.delete();
        m_self = 1'b0;
        #1;
        chk("rst_len", int'(length), 0);
        chk("rst_ready", int'(head_ready), 1);
        chk("rst_self", int'(self_hit), 0);
        chk("rst_rv", int'(r_valid), 0);
    endtask

    // Model a push; returns the number of compares the push should take.
    function automatic int model_push(input logic [2*WW-1:0] h, input bit g);
        int  len = segs.size();
        bit  gr  = g && (len < MAXL);
        int  c   = gr ? len : (len > 0 ? len - 1 : 0);
        for (int i = 0; i < c; i++)
            if (segs[i] == h) m_self = 1'b1;
        segs.push_front(h);
        if (!(gr || len == 0)) void'(segs.pop_back());
        return c;
    endfunction

    function automatic bit model_hit(input logic [2*WW-1:0] p);
        foreach (segs[i]) if (segs[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_push(output int lat, output int early_rv);
        lat = 1;
        early_rv = 0;
        while (!push_done && lat < LIM) begin
            if (r_valid) early_rv++;
            @(posedge slow_clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_push(input int x, input int y, input bit g);
        int c;
        int lat;
        int erv;
        @(negedge slow_clk);
        chk("push_ready", int'(head_ready), 1);
        head_valid = 1'b1;
        head_x = WW'(x);
        head_y = WW'(y);
        grow = g;
        @(posedge slow_clk);
        #1;
        head_valid = 1'b0;
        c = model_push({WW'(x), WW'(y)}, g);
        wait_push(lat, erv);
        chk("push_lat", lat, c + 1);
        chk("push_len", int'(length), segs.size());
        chk("self_hit", int'(self_hit), int'(m_self));
    endtask

    task automatic wait_query(output int lat);
        lat = 1;
        while (!r_valid && lat < LIM) begin
            @(posedge slow_clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_query(input int x, input int y);
        int lat;
        bit eh;
        int len = segs.size();
        eh = model_hit({WW'(x), WW'(y)});
        @(negedge slow_clk);
        chk("q_ready", int'(q_ready), 1);
        q_valid = 1'b1;
        q_x = WW'(x);
        q_y = WW'(y);
        @(posedge slow_clk);
        #1;
        q_valid = 1'b0;
        wait_query(lat);
        chk("q_lat", lat, len + 1);
        chk("q_hit", int'(r_hit), int'(eh));
        @(posedge slow_clk);
        #1;
        chk("q_hold", int'(r_hit), int'(eh));
    endtask

    task automatic do_both(input int hx, input int hy, input bit g,
                           input int qx, input int qy);
        int c;
        int lat;
        int erv;
        bit eh;
        @(negedge slow_clk);
        head_valid = 1'b1;
        head_x = WW'(hx);
        head_y = WW'(hy);
        grow = g;
        q_valid = 1'b1;
        q_x = WW'(qx);
        q_y = WW'(qy);
        @(posedge slow_clk);
        #1;
        head_valid = 1'b0;
        c = model_push({WW'(hx), WW'(hy)}, g);
        wait_push(lat, erv);
        chk("both_push_lat", lat, c + 1);
        chk("both_no_early_rv", erv, 0);
        // Query is taken on the edge that ends the push_done cycle.
        eh = model_hit({WW'(qx), WW'(qy)});
        @(posedge slow_clk);
        #1;
        q_valid = 1'b0;
        wait_query(lat);
        chk("both_q_lat", lat, segs.size() + 1);
        chk("both_q_hit", int'(r_hit), int'(eh));
    endtask

    task automatic reset_mid_query();
        int rv = 0;
        @(negedge slow_clk);
        q_valid = 1'b1;
        q_x = WW'(10);
        q_y = WW'(20);
        @(posedge slow_clk);
        #1;
        q_valid = 1'b0;
        @(negedge slow_clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", int'(head_ready), 1);
        chk("mid_rst_len", int'(length), 0);
        chk("mid_rst_rv", int'(r_valid), 0);
        @(negedge slow_clk);
        reset = 1'b0;
        segs.delete();
        m_self = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge slow_clk);
            #1;
            if (r_valid) rv++;
        end
        chk("mid_rst_no_rv", rv, 0);
        chk("mid_rst_len2", int'(length), 0);
    endtask

    initial begin
        m_self = 1'b0;
        do_reset();
        chk("rst_push_done", int'(push_done), 0);
        chk("rst_rhit", int'(r_hit), 0);
        do_query(10, 20);
        do_push(10, 20, 1'b0);

        do_reset();
        for (int i = 0; i < 4; i++) do_push(10 + i, 20, 1'b1);
        do_query(12, 20);
        do_query(14, 20);
        do_push(14, 20, 1'b0);
        do_query(10, 20);
        do_push(12, 20, 1'b0);
        do_push(30, 40, 1'b0);
        do_push(31, 41, 1'b1);

        do_reset();
        for (int i = 0; i < 17; i++) do_push(i, 5, 1'b1);
        chk("sat_len", int'(length), MAXL);
        do_both(50, 50, 1'b1, 3, 5);
        do_both(51, 50, 1'b0, 0, 5);
        reset_mid_query();

        do_reset();
        for (int n = 0; n < 120; n++) begin
            int x = $urandom_range(13, 10);
            int y = $urandom_range(21, 20);
            if (n % 40 == 39) do_reset();
            else if ($urandom_range(99, 0) < 30) do_query(x, y);
            else do_push(x, y, 1'($urandom_range(1, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
